spike_window_decoder: RTL

- Downstream consumer of the LIF network's spike lines: spike_1..3 and spike_output, concatenated by the integrator.
- Counts rising-edge spikes per channel over a fixed window of enabled clocks.
- Snapshots the counts at window end, then finds the winning (most active) channel with a sequential argmax.
- Presents counts plus winner to a host/readout stage over a valid/ready handshake; counting runs back-to-back with no dead time.

---
 rtl/snn_pkg.sv | 16 +
 rtl/spike_edge_counter.sv | 40 ++++
 rtl/spike_window_decoder.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/snn_pkg.sv
// snn_pkg: shared types, defaults and helpers for the spike window decoder
package snn_pkg;

    typedef enum logic {IDLE, COUNT} win_state_e;

    typedef enum logic [1:0] {AM_IDLE, AM_RUN, AM_LOAD} am_phase_e;

    localparam int N_CH_DEF   = 4;
    localparam int WINDOW_DEF = 16;
    localparam int CNT_W_DEF  = 4;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spike_edge_counter.sv
// spike_edge_counter: one channel of rising-edge detect and saturating spike count
module spike_edge_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_i,
    input  logic             clear_i,
    input  logic             spike_i,
    output logic [CNT_W-1:0] cnt_d_o,
    output logic             sat_d_o
);
    localparam logic [CNT_W-1:0] MAX = '1;

    logic             prev_q;
    logic             sat_q;
    logic [CNT_W-1:0] cnt_q;
    logic             rise;

    // Count value including this cycle's edge, so the window end can snapshot it directly
    always_comb begin
        rise    = spike_i & ~prev_q & en_i;
        cnt_d_o = (rise && cnt_q != MAX) ? cnt_q + 1'b1 : cnt_q;
        sat_d_o = sat_q | (cnt_d_o == MAX);
    end

    // Previous level tracks the line every clock; count and sat flag clear per window
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            prev_q <= 1'b0;
            cnt_q  <= '0;
            sat_q  <= 1'b0;
        end else begin
            prev_q <= spike_i;
            cnt_q  <= clear_i ? '0 : cnt_d_o;
            sat_q  <= clear_i ? 1'b0 : sat_d_o;
        end
    end

endmodule

// File: rtl/spike_window_decoder.sv
// spike_window_decoder: windowed per-channel spike counts with argmax readout over valid/ready
module spike_window_decoder
    import snn_pkg::*;
#(
    parameter int  N_CH   = N_CH_DEF,
    parameter int  WINDOW = WINDOW_DEF,
    parameter int  CNT_W  = CNT_W_DEF,
    localparam int IDX_W  = idx_w(N_CH)
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  enable_i,
    input  logic [N_CH-1:0]       spike_in_i,
    input  logic                  out_ready_i,
    output logic                  out_valid_o,
    output logic [N_CH*CNT_W-1:0] out_counts_o,
    output logic [IDX_W-1:0]      out_winner_o,
    output logic                  out_none_o,
    output logic                  out_sat_o,
    output logic                  out_overrun_o
);
    localparam int WIN_W = idx_w(WINDOW);

    win_state_e                 state_q, state_d;
    logic [WIN_W-1:0]           win_q, win_d;
    logic                       win_end, clear;
    logic [N_CH-1:0][CNT_W-1:0] cnt_next;
    logic [N_CH-1:0]            sat_next;
    logic [N_CH-1:0][CNT_W-1:0] snap_q, snap_d;
    logic                       sat_snap_q, sat_snap_d;
    am_phase_e                  am_q, am_d;
    logic [IDX_W-1:0]           am_idx_q, am_idx_d, best_idx_q, best_idx_d;
    logic [CNT_W-1:0]           best_q, best_d;
    logic [N_CH*CNT_W-1:0]      counts_q, counts_d;
    logic [IDX_W-1:0]           winner_q, winner_d;
    logic                       none_q, none_d, sat_q, sat_d;
    logic                       valid_q, valid_d, overrun_q, overrun_d, xfer;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        spike_edge_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .en_i    (enable_i),
            .clear_i (clear),
            .spike_i (spike_in_i[i]),
            .cnt_d_o (cnt_next[i]),
            .sat_d_o (sat_next[i])
        );
    end

    // Window sequencing: IDLE->COUNT transition is sample 0; dropping enable aborts the window
    always_comb begin
        win_end = (state_q == COUNT) && enable_i && (win_q == WIN_W'(WINDOW - 1));
        clear   = ~enable_i | win_end;
        state_d = enable_i ? COUNT : IDLE;
        win_d   = clear ? '0 : win_q + 1'b1;
    end

    // Snapshot, one-channel-per-clock argmax, and output register with overrun tracking
    always_comb begin
        snap_d     = snap_q;
        sat_snap_d = sat_snap_q;
        am_d       = am_q;
        am_idx_d   = am_idx_q;
        best_d     = best_q;
        best_idx_d = best_idx_q;
        counts_d   = counts_q;
        winner_d   = winner_q;
        none_d     = none_q;
        sat_d      = sat_q;
        xfer       = valid_q & out_ready_i;
        valid_d    = valid_q & ~out_ready_i;
        overrun_d  = overrun_q & ~xfer;
        if (win_end) begin
            snap_d     = cnt_next;
            sat_snap_d = |sat_next;
            am_d       = AM_RUN;
            am_idx_d   = '0;
            best_d     = '0;
            best_idx_d = '0;
        end else if (am_q == AM_RUN) begin
            if (snap_q[am_idx_q] > best_q) begin
                best_d     = snap_q[am_idx_q];
                best_idx_d = am_idx_q;
            end
            am_idx_d = am_idx_q + 1'b1;
            am_d     = (am_idx_q == IDX_W'(N_CH - 1)) ? AM_LOAD : AM_RUN;
        end else if (am_q == AM_LOAD) begin
            am_d      = AM_IDLE;
            counts_d  = snap_q;
            winner_d  = best_idx_q;
            none_d    = (best_q == '0);
            sat_d     = sat_snap_q;
            valid_d   = 1'b1;
            overrun_d = valid_q & ~out_ready_i;
        end
    end

    // State registers; reset discards any window or argmax in flight
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            win_q      <= '0;
            snap_q     <= '0;
            sat_snap_q <= 1'b0;
            am_q       <= AM_IDLE;
            am_idx_q   <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
            counts_q   <= '0;
            winner_q   <= '0;
            none_q     <= 1'b0;
            sat_q      <= 1'b0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            snap_q     <= snap_d;
            sat_snap_q <= sat_snap_d;
            am_q       <= am_d;
            am_idx_q   <= am_idx_d;
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
            counts_q   <= counts_d;
            winner_q   <= winner_d;
            none_q     <= none_d;
            sat_q      <= sat_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign out_valid_o   = valid_q;
    assign out_counts_o  = counts_q;
    assign out_winner_o  = winner_q;
    assign out_none_o    = none_q;
    assign out_sat_o     = sat_q;
    assign out_overrun_o = overrun_q;

endmodule
